// File: rtl/bitserial_neuron_array.sv
// Bit-serial fully connected layer: P lanes, runtime activation precision, AXI-Stream in/out.
// Optional BSNA_RELU_EN: clamp negative results to zero on output.
module bitserial_neuron_array #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned N_IN   = 128,
  parameter int unsigned N_OUT  = 64,
  parameter int unsigned P      = 4,
  parameter int unsigned ACC_W  = 2*DATA_W + $clog2(N_IN)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [$clog2(DATA_W):0]    cfg_prec,
  input  logic [DATA_W-1:0]          s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tlast,
  input  logic                       w_wr_en,
  input  logic [$clog2(N_OUT)-1:0]   w_addr_o,
  input  logic [$clog2(N_IN)-1:0]    w_addr_i,
  input  logic [DATA_W-1:0]          w_data,
  output logic [ACC_W-1:0]           m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic                       busy,
  output logic                       frame_err
);
  localparam int unsigned PREC_W = $clog2(DATA_W) + 1;
  localparam int unsigned B_W    = $clog2(DATA_W);
  localparam int unsigned K_W    = $clog2(N_IN);
  localparam int unsigned NGRP   = (N_OUT + P - 1) / P;
  localparam int unsigned GRP_W  = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam int unsigned LANE_W = (P > 1) ? $clog2(P) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] LOAD    = 2'd1;
  localparam logic [1:0] COMPUTE = 2'd2;
  localparam logic [1:0] DRAIN   = 2'd3;

  logic [1:0]                state, state_nx;
  logic [K_W-1:0]            k, i;
  logic [B_W-1:0]            b;
  logic [PREC_W-1:0]         prec;
  logic [GRP_W-1:0]          grp;
  logic [LANE_W-1:0]         dl, lane_last;
  logic                      cap_done;
  logic [DATA_W-1:0]         act_buf [N_IN];
  logic signed [DATA_W-1:0]  w_mem [P][NGRP][N_IN];
  logic signed [ACC_W-1:0]   acc [P];
  logic [ACC_W-1:0]          out_reg [P];
  logic signed [ACC_W-1:0]   term [P];
  logic [P-1:0]              lane_valid;

  logic                      in_hs, out_hs, frame_end, comp_last, b_msb, bit_on, grp_last;
  logic [PREC_W-1:0]         prec_in, beat_prec;

  // Keep the low pr bits of v, sign-extended from bit pr-1.
  function automatic logic [DATA_W-1:0] sext_fn(input logic [DATA_W-1:0] v,
                                                input logic [PREC_W-1:0] pr);
    int sh;
    sh = int'(DATA_W) - int'(pr);
    return DATA_W'($signed(v << sh) >>> sh);
  endfunction

  function automatic logic [ACC_W-1:0] act_fn(input logic signed [ACC_W-1:0] a);
`ifdef BSNA_RELU_EN
    return a[ACC_W-1] ? '0 : a;
`else
    return a;
`endif
  endfunction

  always_comb begin
    int rem;
    in_hs     = s_axis_tvalid & s_axis_tready;
    out_hs    = m_axis_tvalid & m_axis_tready;
    prec_in   = (cfg_prec == '0 || cfg_prec > PREC_W'(DATA_W)) ? PREC_W'(DATA_W) : cfg_prec;
    beat_prec = (k == '0) ? prec_in : prec;
    frame_end = in_hs & (s_axis_tlast | (k == K_W'(N_IN - 1)));
    b_msb     = (b == B_W'(prec - PREC_W'(1)));
    comp_last = (i == K_W'(N_IN - 1)) & b_msb;
    bit_on    = act_buf[i][b];
    grp_last  = (grp == GRP_W'(NGRP - 1));
    rem       = int'(N_OUT) - int'(grp) * int'(P);
    lane_last = (rem >= int'(P)) ? LANE_W'(P - 1) : LANE_W'(rem - 1);
    for (int p = 0; p < int'(P); p++) begin
      lane_valid[p] = (int'(grp) * int'(P) + p) < int'(N_OUT);
      term[p]       = ACC_W'(w_mem[p][grp][i]) <<< b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (s_axis_tvalid) state_nx = LOAD;
      LOAD:    if (frame_end)     state_nx = COMPUTE;
      COMPUTE: if (comp_last)     state_nx = DRAIN;
      DRAIN:   if (cap_done && out_hs && dl == lane_last)
                 state_nx = grp_last ? IDLE : COMPUTE;
      default: state_nx = IDLE;
    endcase
  end

  // Activation buffer; early tlast zeroes the tail so stale data never contributes.
  always_ff @(posedge clk) begin
    if (state == LOAD && in_hs) begin
      for (int j = 0; j < int'(N_IN); j++) begin
        if (j == int'(k))                    act_buf[j] <= sext_fn(s_axis_tdata, beat_prec);
        else if (j > int'(k) && s_axis_tlast) act_buf[j] <= '0;
      end
    end
  end

  // Weights are banked by lane: neuron n lives in bank n%P, row n/P.
  always_ff @(posedge clk) begin
    if (w_wr_en && !busy && int'(w_addr_o) < int'(N_OUT))
      w_mem[LANE_W'(int'(w_addr_o) % int'(P))][GRP_W'(int'(w_addr_o) / int'(P))][w_addr_i] <= w_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_axis_tready <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      busy          <= 1'b0;
      frame_err     <= 1'b0;
      k             <= '0;
      i             <= '0;
      b             <= '0;
      prec          <= '0;
      grp           <= '0;
      dl            <= '0;
      cap_done      <= 1'b0;
      for (int p = 0; p < int'(P); p++) begin
        acc[p]     <= '0;
        out_reg[p] <= '0;
      end
    end else begin
      s_axis_tready <= (state_nx == LOAD);
      busy          <= (state_nx != IDLE);
      frame_err     <= 1'b0;
      unique case (state)
        LOAD: if (in_hs) begin
          if (k == '0) prec <= prec_in;
          k <= k + K_W'(1);
          if (frame_end) begin
            k         <= '0;
            frame_err <= ~s_axis_tlast;
          end
        end
        COMPUTE: begin
          for (int p = 0; p < int'(P); p++) begin
            if (!lane_valid[p]) acc[p] <= '0;
            else if (bit_on)    acc[p] <= b_msb ? acc[p] - term[p] : acc[p] + term[p];
          end
          if (b_msb) begin
            b <= '0;
            i <= i + K_W'(1);
          end else begin
            b <= b + B_W'(1);
          end
          if (comp_last) begin
            i        <= '0;
            cap_done <= 1'b0;
          end
        end
        DRAIN: begin
          if (!cap_done) begin
            for (int p = 0; p < int'(P); p++) begin
              out_reg[p] <= act_fn(acc[p]);
              acc[p]     <= '0;
            end
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= act_fn(acc[0]);
            m_axis_tlast  <= (int'(grp) * int'(P) == int'(N_OUT) - 1);
            dl            <= '0;
            cap_done      <= 1'b1;
          end else if (out_hs) begin
            if (dl == lane_last) begin
              m_axis_tvalid <= 1'b0;
              m_axis_tlast  <= 1'b0;
              grp           <= grp_last ? '0 : grp + GRP_W'(1);
            end else begin
              dl           <= dl + LANE_W'(1);
              m_axis_tdata <= out_reg[dl + LANE_W'(1)];
              m_axis_tlast <= (int'(grp) * int'(P) + int'(dl) + 1 == int'(N_OUT) - 1);
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bitserial_neuron_array.sv
// Directed bench for bitserial_neuron_array (DATA_W=8, N_IN=4, N_OUT=6, P=4).
module tb_bitserial_neuron_array;
  localparam int DATA_W = 8;
  localparam int N_IN   = 4;
  localparam int N_OUT  = 6;
  localparam int P      = 4;
  localparam int ACC_W  = 18;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        cfg_prec;
  logic [7:0]        s_axis_tdata;
  logic              s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic              w_wr_en;
  logic [2:0]        w_addr_o;
  logic [1:0]        w_addr_i;
  logic [7:0]        w_data;
  logic [ACC_W-1:0]  m_axis_tdata;
  logic              m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic              busy, frame_err;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int ferr_cnt = 0;
  logic [7:0]             xs [N_IN];
  logic signed [ACC_W-1:0] exp_v [N_OUT];

  bitserial_neuron_array #(.DATA_W(DATA_W), .N_IN(N_IN), .N_OUT(N_OUT), .P(P), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .cfg_prec(cfg_prec),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .w_wr_en(w_wr_en), .w_addr_o(w_addr_o), .w_addr_i(w_addr_i),
    .w_data(w_data), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc++;
    if (frame_err) ferr_cnt++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_w(input int o, input int i, input int v);
    w_wr_en  = 1'b1;
    w_addr_o = 3'(o);
    w_addr_i = 2'(i);
    w_data   = 8'(v);
    tick();
    w_wr_en  = 1'b0;
  endtask

  task automatic write_lin_weights;
    for (int o = 0; o < N_OUT; o++)
      for (int i = 0; i < N_IN; i++) write_w(o, i, o + 1);
  endtask

  task automatic set_exp_lin(input int mult);
    for (int o = 0; o < N_OUT; o++) exp_v[o] = ACC_W'(mult * (o + 1));
  endtask

  task automatic send_frame(input int n, input bit with_last, input int prec);
    int t;
    for (int bt = 0; bt < n; bt++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = xs[bt];
      s_axis_tlast  = with_last && (bt == n - 1);
      cfg_prec      = 4'(prec);
      t = 0;
      while (!s_axis_tready && t < 50) begin
        tick();
        t++;
      end
      if (!s_axis_tready) begin
        checks++;
        $display("FAIL send_ready: beat %0d tready=%0b required 1", bt, s_axis_tready);
        s_axis_tvalid = 1'b0;
        return;
      end
      tick();
      hs_cyc = cyc;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic collect(input string name, input int lat_exp, input int stall_beat);
    int t, got;
    logic [ACC_W-1:0] hd;
    logic hl;
    m_axis_tready = 1'b1;
    t = 0;
    while (!m_axis_tvalid && t < 200) begin
      tick();
      t++;
    end
    if (lat_exp >= 0) begin
      checks++;
      if ((cyc - hs_cyc) !== lat_exp)
        $display("FAIL %s_latency: got %0d cycles required %0d", name, cyc - hs_cyc, lat_exp);
      else passed++;
    end
    got = 0;
    t = 0;
    while (got < N_OUT && t < 300) begin
      if (m_axis_tvalid) begin
        if (got == stall_beat) begin
          m_axis_tready = 1'b0;
          hd = m_axis_tdata;
          hl = m_axis_tlast;
          repeat (5) begin
            tick();
            checks++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== hd || m_axis_tlast !== hl)
              $display("FAIL %s_hold: valid=%0b data=%0d last=%0b required 1/%0d/%0b",
                       name, m_axis_tvalid, $signed(m_axis_tdata), m_axis_tlast, $signed(hd), hl);
            else passed++;
          end
          m_axis_tready = 1'b1;
        end
        checks++;
        if (m_axis_tdata !== exp_v[got])
          $display("FAIL %s_data[%0d]: got %0d required %0d", name, got,
                   $signed(m_axis_tdata), exp_v[got]);
        else passed++;
        checks++;
        if (m_axis_tlast !== (got == N_OUT - 1))
          $display("FAIL %s_last[%0d]: got %0b required %0b", name, got, m_axis_tlast, got == N_OUT - 1);
        else passed++;
        got++;
      end
      tick();
      t++;
    end
    checks++;
    if (got !== N_OUT) $display("FAIL %s_count: got %0d beats required %0d", name, got, N_OUT);
    else passed++;
    checks++;
    if (busy !== 1'b0 || m_axis_tvalid !== 1'b0)
      $display("FAIL %s_idle: busy=%0b valid=%0b required 0/0", name, busy, m_axis_tvalid);
    else passed++;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cfg_prec = 4'd8; s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    w_wr_en = 1'b0; w_addr_o = '0; w_addr_i = '0; w_data = '0; m_axis_tready = 1'b1;
    repeat (3) tick();
    checks++;
    if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, busy, frame_err} !== 5'b0 || m_axis_tdata !== '0)
      $display("FAIL reset: tready=%0b tvalid=%0b tlast=%0b busy=%0b ferr=%0b tdata=%0d required all 0",
               s_axis_tready, m_axis_tvalid, m_axis_tlast, busy, frame_err, m_axis_tdata);
    else passed++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_full_precision;
    write_lin_weights();
    xs[0] = 8'd1; xs[1] = 8'd2; xs[2] = 8'd3; xs[3] = 8'd4;
    set_exp_lin(10);
    send_frame(4, 1'b1, 8);
    collect("full", 33, -1);
  endtask

  task automatic test_negative;
    for (int o = 0; o < N_OUT; o++)
      for (int i = 0; i < N_IN; i++) write_w(o, i, -1);
`ifdef BSNA_RELU_EN
    set_exp_lin(0);
`else
    for (int o = 0; o < N_OUT; o++) exp_v[o] = -18'sd10;
`endif
    send_frame(4, 1'b1, 8);
    collect("neg", 33, -1);
  endtask

  task automatic test_reduced_precision;
    for (int o = 0; o < N_OUT; o++) write_w(o, 0, -3);
    xs[0] = 8'h0F; xs[1] = 8'd0; xs[2] = 8'd0; xs[3] = 8'd0;
    for (int o = 0; o < N_OUT; o++) exp_v[o] = 18'sd3;
    send_frame(4, 1'b1, 4);
    collect("prec4", 17, -1);
  endtask

  task automatic test_frame_end;
    write_lin_weights();
    xs[0] = 8'd1; xs[1] = 8'd2; xs[2] = 8'd3; xs[3] = 8'd4;
    set_exp_lin(10);
    ferr_cnt = 0;
    send_frame(4, 1'b0, 8);
    collect("nolast", 33, -1);
    checks++;
    if (ferr_cnt !== 1) $display("FAIL nolast_ferr: got %0d pulses required 1", ferr_cnt);
    else passed++;
    xs[0] = 8'd1; xs[1] = 8'd2;
    set_exp_lin(3);
    ferr_cnt = 0;
    send_frame(2, 1'b1, 8);
    collect("early", 33, -1);
    checks++;
    if (ferr_cnt !== 0) $display("FAIL early_ferr: got %0d pulses required 0", ferr_cnt);
    else passed++;
  endtask

  task automatic test_backpressure;
    xs[0] = 8'd1; xs[1] = 8'd2; xs[2] = 8'd3; xs[3] = 8'd4;
    set_exp_lin(10);
    send_frame(4, 1'b1, 8);
    write_w(0, 0, 100);
    collect("bp", -1, 2);
    send_frame(4, 1'b1, 8);
    collect("after_busy_wr", 33, -1);
  endtask

  task automatic test_reset_mid_compute;
    int seen;
    xs[0] = 8'd1; xs[1] = 8'd2; xs[2] = 8'd3; xs[3] = 8'd4;
    send_frame(4, 1'b1, 8);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0) $display("FAIL rst_busy: got %0b required 0", busy);
    else passed++;
    seen = 0;
    repeat (40) begin
      if (m_axis_tvalid) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) $display("FAIL rst_no_beats: got %0d valid cycles required 0", seen);
    else passed++;
    set_exp_lin(10);
    send_frame(4, 1'b1, 8);
    collect("post_rst", 33, -1);
  endtask

  initial begin
    test_reset();
    test_full_precision();
    test_negative();
    test_reduced_precision();
    test_frame_end();
    test_backpressure();
    test_reset_mid_compute();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
